// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the vectored interrupt controller
// Purpose: FSM state encoding and config register addresses used by int_ctrl.
// Ports: none (package).
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } state_e;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_GIE  = 2'd1;
  localparam logic [1:0] CFG_PEND = 2'd2;
  localparam logic [1:0] CFG_EPC  = 2'd3;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - fixed-priority encoder, lowest set index wins
// Purpose: picks the highest-priority eligible interrupt source.
// Ports:
//   req  in  NUM_SRC  request vector
//   any  out 1        at least one request set
//   id   out ID_W     index of the lowest set request (0 when none)
module int_prio_enc #(
  parameter  int NUM_SRC = 4,
  localparam int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the last hit, the lowest index, is kept.
  always_comb begin
    any = |req;
    id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - vectored interrupt controller driving the fetch unit's INT_Vector path
// Purpose: latches irq edges, masks/gates them, requests the control unit, supplies the
//          handler address on entry and the saved PC/flags on return.
// Ports:
//   clk, Rst                 clock (state on negedge), async active-low reset
//   irq_in                   interrupt sources, rising edge sets PENDING
//   pc_in, nzcv_in           PC and flags captured on int_ack
//   int_ack, iret            entry / return strobes from the control unit
//   cfg_we/addr/wdata/rdata  config register port (MASK, GIE, PENDING W1C, EPC)
//   int_req, int_vector      request and vector to control / fetch units
//   int_active, irq_id       in-service flag and winning/active source id
//   nzcv_restore(_en)        saved flags and their restore strobe
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter  int          NUM_SRC  = 4,
  parameter  logic [31:0] VEC_BASE = 32'h0000_0080,
  localparam int          ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [31:0]        pc_in,
  input  logic [3:0]         nzcv_in,
  input  logic               int_ack,
  input  logic               iret,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               int_req,
  output logic [31:0]        int_vector,
  output logic               int_active,
  output logic [ID_W-1:0]    irq_id,
  output logic [3:0]         nzcv_restore,
  output logic               nzcv_restore_en
);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   mask_q, pend_q, pend_d, irq_prev_q;
  logic                 gie_q;
  logic [31:0]          epc_q;
  logic [3:0]           saved_nzcv_q;
  logic [ID_W-1:0]      active_id_q;
  logic [NUM_SRC-1:0]   eligible, pend_set;
  logic                 elig_any, take_ack;
  logic [ID_W-1:0]      winner;
  logic                 unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:NUM_SRC];

  assign pend_set = irq_in & ~irq_prev_q;
  assign eligible = pend_q & mask_q;

  int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req (eligible),
    .any (elig_any),
    .id  (winner)
  );

  // Clears first, then new edges, so a fresh edge survives a same-cycle clear.
  always_comb begin
    pend_d = pend_q;
    if (cfg_we && cfg_addr == CFG_PEND) pend_d = pend_d & ~cfg_wdata[NUM_SRC-1:0];
    if (take_ack) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ID_W'(i) == winner) pend_d[i] = 1'b0;
      end
    end
    pend_d = pend_d | pend_set;
  end

  always_comb begin
    state_d         = state_q;
    int_req         = 1'b0;
    int_active      = 1'b0;
    nzcv_restore_en = 1'b0;
    take_ack        = 1'b0;
    case (state_q)
      IDLE: begin
        if (gie_q && elig_any) state_d = REQ;
      end
      REQ: begin
        int_req = 1'b1;
        // Ack has priority over a losing condition and over a same-cycle iret.
        if (int_ack) begin
          take_ack = 1'b1;
          state_d  = SERVICE;
        end else if (!elig_any || !gie_q) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        int_active = 1'b1;
        if (iret) begin
          nzcv_restore_en = 1'b1;
          state_d         = RETURN;
        end
      end
      RETURN: begin
        // One dead cycle lets at least one non-handler instruction retire.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      gie_q        <= 1'b0;
      pend_q       <= '0;
      irq_prev_q   <= '0;
      epc_q        <= '0;
      saved_nzcv_q <= '0;
      active_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      irq_prev_q <= irq_in;
      if (cfg_we && cfg_addr == CFG_MASK) mask_q <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_we && cfg_addr == CFG_GIE)  gie_q  <= cfg_wdata[0];
      if (take_ack) begin
        epc_q        <= pc_in;
        saved_nzcv_q <= nzcv_in;
        active_id_q  <= winner;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_MASK: cfg_rdata = {{(32-NUM_SRC){1'b0}}, mask_q};
      CFG_GIE:  cfg_rdata = {31'b0, gie_q};
      CFG_PEND: cfg_rdata = {{(32-NUM_SRC){1'b0}}, pend_q};
      CFG_EPC:  cfg_rdata = epc_q;
      default:  cfg_rdata = '0;
    endcase
  end

  // In service the vector path carries the return PC instead of a handler address.
  assign int_vector   = (state_q == SERVICE) ? epc_q
                      : VEC_BASE + {{(30-ID_W){1'b0}}, winner, 2'b00};
  assign irq_id       = (state_q == SERVICE || state_q == RETURN) ? active_id_q : winner;
  assign nzcv_restore = saved_nzcv_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

  logic        clk;
  logic        Rst;
  logic [3:0]  irq_in;
  logic [31:0] pc_in;
  logic [3:0]  nzcv_in;
  logic        int_ack;
  logic        iret;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        int_req;
  logic [31:0] int_vector;
  logic        int_active;
  logic [1:0]  irq_id;
  logic [3:0]  nzcv_restore;
  logic        nzcv_restore_en;

  int errors = 0;
  int checks = 0;

  int_ctrl #(.NUM_SRC(4), .VEC_BASE(32'h0000_0080)) dut (
    .clk             (clk),
    .Rst             (Rst),
    .irq_in          (irq_in),
    .pc_in           (pc_in),
    .nzcv_in         (nzcv_in),
    .int_ack         (int_ack),
    .iret            (iret),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .cfg_rdata       (cfg_rdata),
    .int_req         (int_req),
    .int_vector      (int_vector),
    .int_active      (int_active),
    .irq_id          (irq_id),
    .nzcv_restore    (nzcv_restore),
    .nzcv_restore_en (nzcv_restore_en)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One DUT state update (negedge), then settle just after the following posedge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_in = v;
    tick();
    irq_in = '0;
  endtask

  initial begin
    Rst = 1'b0; irq_in = '0; pc_in = '0; nzcv_in = '0; int_ack = 1'b0; iret = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #12 Rst = 1'b1;

    // Reach REQ, then reset asynchronously in the middle of it.
    cfg_write(2'd0, 32'hF);
    cfg_write(2'd1, 32'h1);
    pulse(4'b0010);
    tick();
    check("pre_reset_req", 32'(int_req), 32'd1);
    #2 Rst = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_int_active", 32'(int_active), 32'd0);
    check("rst_restore_en", 32'(nzcv_restore_en), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    check("rst_vector", int_vector, 32'h80);
    read_chk("rst_mask", 2'd0, 32'h0);
    read_chk("rst_gie", 2'd1, 32'h0);
    read_chk("rst_pend", 2'd2, 32'h0);
    read_chk("rst_epc", 2'd3, 32'h0);

    // Single source 2, two-edge latency.
    cfg_write(2'd0, 32'hF);
    cfg_write(2'd1, 32'h1);
    pulse(4'b0100);
    check("lat_req_low", 32'(int_req), 32'd0);
    read_chk("lat_pend", 2'd2, 32'h4);
    tick();
    check("s2_req", 32'(int_req), 32'd1);
    check("s2_vector", int_vector, 32'h88);
    check("s2_id", 32'(irq_id), 32'd2);

    // Ack with a simultaneous iret: ack wins, no restore strobe.
    int_ack = 1'b1; iret = 1'b1; pc_in = 32'h40; nzcv_in = 4'b0100;
    #1;
    check("ack_iret_no_restore", 32'(nzcv_restore_en), 32'd0);
    tick();
    int_ack = 1'b0; iret = 1'b0; pc_in = '0; nzcv_in = '0;
    read_chk("ack_epc", 2'd3, 32'h40);
    read_chk("ack_pend", 2'd2, 32'h0);
    check("svc_active", 32'(int_active), 32'd1);
    check("svc_vector", int_vector, 32'h40);
    check("svc_req", 32'(int_req), 32'd0);
    check("svc_id", 32'(irq_id), 32'd2);

    // New edge in service just pends; a stray ack is ignored.
    int_ack = 1'b1; pc_in = 32'h99;
    pulse(4'b0001);
    int_ack = 1'b0; pc_in = '0;
    check("svc_no_nest_req", 32'(int_req), 32'd0);
    check("svc_still_active", 32'(int_active), 32'd1);
    read_chk("svc_epc_kept", 2'd3, 32'h40);
    read_chk("svc_pend0", 2'd2, 32'h1);

    // Return: strobe in the same cycle, then RETURN, IDLE, REQ.
    iret = 1'b1;
    #1;
    check("iret_restore_en", 32'(nzcv_restore_en), 32'd1);
    check("iret_restore", 32'(nzcv_restore), 32'h4);
    tick();
    iret = 1'b0;
    check("ret_req", 32'(int_req), 32'd0);
    check("ret_active", 32'(int_active), 32'd0);
    check("ret_restore_en", 32'(nzcv_restore_en), 32'd0);
    tick();
    check("idle_req", 32'(int_req), 32'd0);
    tick();
    check("s0_req", 32'(int_req), 32'd1);
    check("s0_vector", int_vector, 32'h80);
    int_ack = 1'b1; pc_in = 32'h44;
    tick();
    int_ack = 1'b0; iret = 1'b1;
    tick();
    iret = 1'b0;
    tick();
    read_chk("s0_pend_clear", 2'd2, 32'h0);
    // iret outside SERVICE gives no strobe.
    iret = 1'b1;
    #1;
    check("iret_idle_no_restore", 32'(nzcv_restore_en), 32'd0);
    tick();
    iret = 1'b0;

    // Simultaneous sources 3 and 1: 1 first, 3 after return.
    pulse(4'b1010);
    tick();
    check("s31_req", 32'(int_req), 32'd1);
    check("s31_vector", int_vector, 32'h84);
    check("s31_id", 32'(irq_id), 32'd1);
    int_ack = 1'b1; pc_in = 32'h50;
    tick();
    int_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s31_svc_req_low", 32'(int_req), 32'd0);
      tick();
    end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    tick();
    tick();
    check("s3_req", 32'(int_req), 32'd1);
    check("s3_vector", int_vector, 32'h8C);
    check("s3_id", 32'(irq_id), 32'd3);

    // Mask off in REQ: request drops next cycle, pending retained.
    cfg_write(2'd0, 32'h0);
    check("mask0_req_still", 32'(int_req), 32'd1);
    tick();
    check("mask0_req_drop", 32'(int_req), 32'd0);
    read_chk("mask0_pend", 2'd2, 32'h8);
    cfg_write(2'd0, 32'hF);
    tick();
    check("remask_req", 32'(int_req), 32'd1);
    check("remask_vector", int_vector, 32'h8C);

    // GIE=0 written with ack: ack wins.
    int_ack = 1'b1; pc_in = 32'h60;
    cfg_write(2'd1, 32'h0);
    int_ack = 1'b0;
    check("gie_ack_active", 32'(int_active), 32'd1);
    read_chk("gie_ack_epc", 2'd3, 32'h60);
    read_chk("gie_ack_gie", 2'd1, 32'h0);
    iret = 1'b1;
    tick();
    iret = 1'b0;
    tick();
    check("gie_ack_idle", 32'(int_req), 32'd0);

    // Edge with W1C of the same bit: the edge wins; GIE=0 keeps int_req low.
    irq_in = 4'b0001;
    cfg_write(2'd2, 32'h1);
    irq_in = '0;
    read_chk("w1c_edge_wins", 2'd2, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gie0_req_low", 32'(int_req), 32'd0);
    end
    cfg_write(2'd2, 32'h1);
    read_chk("w1c_clear", 2'd2, 32'h0);
    cfg_write(2'd3, 32'hDEAD);
    read_chk("epc_ro", 2'd3, 32'h60);
    cfg_write(2'd1, 32'hFFFF_FFFF);
    read_chk("gie_upper_zero", 2'd1, 32'h1);

    // Preemption in REQ by a higher-priority arrival.
    pulse(4'b0100);
    tick();
    check("pre_vector", int_vector, 32'h88);
    pulse(4'b0001);
    check("preempt_req", 32'(int_req), 32'd1);
    check("preempt_vector", int_vector, 32'h80);
    check("preempt_id", 32'(irq_id), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
